// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter between NUM_REQ requesters. A requester
//   wins the transmitter by round-robin and keeps it for a burst: it ends on
//   the requester's last byte, after MAX_BURST bytes, when the requester runs
//   dry at a done edge, or when the watchdog gives up on a missing done.
//
// Ports
//   i_Clk, i_Rst            clock; asynchronous active-high reset
//   i_Req / i_Req_Last      per-requester byte-valid and end-of-burst flags
//   i_Req_Data              byte k at [8k+7:8k]
//   o_Ack                   1-clk pulse on the owner bit: byte taken
//   o_Grant                 one-hot owner, zero when idle
//   o_TX_DV / o_TX_Byte     start pulse and byte for the transmitter
//   i_TX_Active / i_TX_Done transmitter busy level and stop-bit-done pulse
//   o_Busy                  a byte is outstanding (WAIT_DONE)
//   o_Timeout               1-clk pulse when the watchdog forces a release
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int MAX_BURST    = 16,
  parameter int DONE_TIMEOUT = 4000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int WD_W = $clog2(DONE_TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);
  localparam logic [IDX_W:0]   NREQ_W    = (IDX_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t                     state, state_nx;
  logic [IDX_W-1:0]           ptr, ptr_nx;
  logic [IDX_W-1:0]           owner, owner_nx;
  logic                       last_q, last_nx;
  logic [7:0]                 cnt, cnt_nx;
  logic [WD_W-1:0]            wd, wd_nx;
  logic [NUM_REQ-1:0]         grant_nx, ack_nx;
  logic                       dv_nx, to_nx;
  logic [7:0]                 byte_nx;

  // Byte lanes viewed as a packed array so a lane can be picked by index.
  logic [NUM_REQ-1:0][7:0]    req_byte;
  assign req_byte = i_Req_Data;

  // Round-robin search: rotate requests so bit 0 is the pointer's requester,
  // take the lowest set bit, then rotate the offset back to an index.
  logic [2*NUM_REQ-1:0]       req_dbl;
  logic [NUM_REQ-1:0]         req_rot;
  logic                       win_vld;
  logic [IDX_W-1:0]           win_off, win;
  logic [IDX_W:0]             win_sum;

  assign req_dbl = {i_Req, i_Req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    win_vld = |req_rot;
    win_off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_rot[i]) win_off = IDX_W'(i);
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    if (win_sum >= NREQ_W) win_sum = win_sum - NREQ_W;
    win = win_sum[IDX_W-1:0];
  end

  // Pointer after the current owner releases.
  logic [IDX_W:0]             own_inc;
  logic [IDX_W-1:0]           ptr_after;
  always_comb begin
    own_inc   = {1'b0, owner} + {{IDX_W{1'b0}}, 1'b1};
    ptr_after = (own_inc >= NREQ_W) ? '0 : own_inc[IDX_W-1:0];
  end

  logic                       issue, release_bus;
  logic [IDX_W-1:0]           issue_idx;

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    owner_nx    = owner;
    last_nx     = last_q;
    cnt_nx      = cnt;
    wd_nx       = wd;
    grant_nx    = o_Grant;
    byte_nx     = o_TX_Byte;
    dv_nx       = 1'b0;
    ack_nx      = '0;
    to_nx       = 1'b0;
    issue       = 1'b0;
    release_bus = 1'b0;
    issue_idx   = owner;

    case (state)
      IDLE: begin
        // A transmitter still shifting (e.g. after reset mid-byte) blocks
        // arbitration; stray done pulses are ignored here.
        if (win_vld && !i_TX_Active) begin
          issue     = 1'b1;
          issue_idx = win;
          cnt_nx    = 8'd1;
          state_nx  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_nx = wd + 1'b1;
        // Done is checked first so a done on the expiry edge is not a timeout.
        if (i_TX_Done) begin
          if (i_Req[owner] && !last_q && (cnt < BURST_MAX)) begin
            issue  = 1'b1;
            cnt_nx = cnt + 8'd1;
          end else begin
            release_bus = 1'b1;
          end
        end else if (wd == WD_LAST) begin
          release_bus = 1'b1;
          to_nx       = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (issue) begin
      owner_nx = issue_idx;
      grant_nx = NUM_REQ'(1) << issue_idx;
      ack_nx   = NUM_REQ'(1) << issue_idx;
      byte_nx  = req_byte[issue_idx];
      last_nx  = i_Req_Last[issue_idx];
      dv_nx    = 1'b1;
      wd_nx    = '0;
    end

    // Release always lands in IDLE, so the next grant is at least one
    // cycle later.
    if (release_bus) begin
      grant_nx = '0;
      ptr_nx   = ptr_after;
      wd_nx    = '0;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      ptr       <= '0;
      owner     <= '0;
      last_q    <= 1'b0;
      cnt       <= '0;
      wd        <= '0;
      o_Grant   <= '0;
      o_Ack     <= '0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
      o_Timeout <= 1'b0;
      o_Busy    <= 1'b0;
    end else begin
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      last_q    <= last_nx;
      cnt       <= cnt_nx;
      wd        <= wd_nx;
      o_Grant   <= grant_nx;
      o_Ack     <= ack_nx;
      o_TX_DV   <= dv_nx;
      o_TX_Byte <= byte_nx;
      o_Timeout <= to_nx;
      o_Busy    <= (state_nx == WAIT_DONE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-backed requesters, a transmitter model
// with fixed/random/hung done behaviour, an event-level reference model and
// directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int MB = 6;
  localparam int DT = 50;
  localparam int QD = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]       req = '0, req_last = '0, ack, grant;
  logic [NR-1:0][7:0]  req_data = '0;
  logic                tx_dv, tx_active = 1'b0, tx_done = 1'b0, busy, timeout;
  logic [7:0]          tx_byte;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .MAX_BURST(MB), .DONE_TIMEOUT(DT)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Req_Data(req_data), .i_Req_Last(req_last),
    .o_Ack(ack), .o_Grant(grant), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .i_TX_Active(tx_active), .i_TX_Done(tx_done), .o_Busy(busy), .o_Timeout(timeout));

  int checks = 0, failures = 0;

  // requester queues (stimulus writes tail, driver owns head)
  logic [7:0] qb [NR][QD];
  bit         ql [NR][QD];
  int head [NR] = '{default:0};
  int tail [NR] = '{default:0};
  bit flush = 0;

  // transmitter model controls
  bit rand_mode = 0, hang_mode = 0, hold = 0;
  int fix_delay = 20;
  bit tx_busy = 0, tx_hang = 0;
  int tx_left = 0;

  // reference model state
  int m_cyc = 0, m_owner = -1, m_ptr = 0, m_cnt = 0, m_issue = 0;
  bit m_last = 0;
  logic [NR-1:0] e_grant = '0, e_ack = '0;
  logic e_dv = 0, e_to = 0, e_busy = 0;
  logic [7:0] e_byte = '0;

  // observation log
  int log_b [4096];
  int log_c [4096];
  int log_n = 0, to_n = 0;
  int ack_n [NR] = '{default:0};
  int gcyc  [NR] = '{default:0};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic enqueue(int k, logic [7:0] b, bit l);
    qb[k][tail[k] % QD] = b;
    ql[k][tail[k] % QD] = l;
    tail[k]++;
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (head[k] != tail[k]) return 0;
    return 1;
  endfunction

  // ---------------- reference model ----------------
  task automatic m_issue_to(int w);
    m_owner = w;
    e_grant = '0; e_grant[w] = 1'b1;
    e_ack   = '0; e_ack[w]   = 1'b1;
    e_byte  = req_data[w];
    m_last  = req_last[w];
    e_dv    = 1'b1;
    m_issue = m_cyc;
  endtask

  task automatic m_release();
    m_ptr   = (m_owner + 1) % NR;
    m_owner = -1;
    e_grant = '0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_last = 0;
      e_grant = '0; e_ack = '0; e_dv = 0; e_to = 0; e_busy = 0; e_byte = '0;
    end else begin
      m_cyc++;
      e_dv = 0; e_ack = '0; e_to = 0;
      if (m_owner < 0) begin
        if (req != '0 && !tx_active) begin
          int w;
          w = -1;
          for (int i = 0; i < NR; i++)
            if (w < 0 && req[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
          m_issue_to(w);
          m_cnt = 1;
        end
      end else if (tx_done) begin
        if (req[m_owner] && !m_last && m_cnt < MB) begin
          m_issue_to(m_owner);
          m_cnt++;
        end else m_release();
      end else if (m_cyc - m_issue >= DT) begin
        m_release();
        e_to = 1;
      end
      e_busy = (m_owner >= 0);
    end
  end

  // ---------------- input driver: requesters + transmitter ----------------
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      if (flush) head[k] = tail[k];
      else if (ack[k] && head[k] != tail[k]) head[k]++;
      req[k]      = (head[k] != tail[k]);
      req_data[k] = qb[k][head[k] % QD];
      req_last[k] = ql[k][head[k] % QD] && req[k];
    end
    tx_done = 0;
    if (rst) begin
      tx_busy = 0; tx_hang = 0; tx_left = 0;
    end else if (tx_dv) begin
      tx_hang = hang_mode || (rand_mode && $urandom_range(0, 19) == 0);
      tx_left = (rand_mode ? int'($urandom_range(2, 30)) : fix_delay) - 1;
      tx_busy = !tx_hang;
    end else if (tx_busy) begin
      tx_left--;
      if (tx_left <= 0) begin tx_done = 1; tx_busy = 0; end
    end else if (rand_mode && m_owner < 0 && $urandom_range(0, 9) == 0) begin
      tx_done = 1;
    end
    tx_active = tx_busy || hold ||
                (rand_mode && !tx_busy && !tx_done && $urandom_range(0, 7) == 0);
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    chk("grant",   32'(grant),   32'(e_grant));
    chk("ack",     32'(ack),     32'(e_ack));
    chk("tx_dv",   32'(tx_dv),   32'(e_dv));
    chk("tx_byte", 32'(tx_byte), 32'(e_byte));
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("busy",    32'(busy),    32'(e_busy));
    if (tx_dv === 1'b1) begin
      log_b[log_n] = int'(tx_byte); log_c[log_n] = m_cyc; log_n++;
    end
    if (timeout === 1'b1) to_n++;
    for (int k = 0; k < NR; k++) begin
      if (ack[k] === 1'b1) ack_n[k]++;
      if (grant[k] === 1'b1) gcyc[k]++;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1; flush = 1; rand_mode = 0; hang_mode = 0; hold = 0;
    repeat (2) @(negedge clk);
    flush = 0; rst = 0;
    @(negedge clk);
  endtask

  task automatic drain(int budget, string nm);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && busy === 1'b0 && !tx_busy)) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_%s actual=timeout_after_%0d expected=idle", nm, n);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit actual=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int base, a2, g2, tb0;
    // ---- reset state ----
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_byte",  32'(tx_byte), 0);

    // ---- 1: single requester, done 20 clk after DV ----
    fix_delay = 20;
    base = log_n; a2 = ack_n[2]; g2 = gcyc[2]; tb0 = gcyc[0];
    enqueue(2, 8'h41, 1);
    drain(200, "t1");
    chk("t1_count", 32'(log_n - base), 1);
    chk("t1_byte",  32'(log_b[base]), 32'h41);
    chk("t1_acks",  32'(ack_n[2] - a2), 1);
    chk("t1_grant_cycles", 32'(gcyc[2] - g2), 20);
    chk("t1_grant_other",  32'(gcyc[0] - tb0), 0);
    chk("t1_grant_final",  32'(grant), 0);
    base = log_n;
    enqueue(0, 8'h50, 1); enqueue(3, 8'h53, 1);
    drain(200, "t1b");
    chk("t1_ptr3_first", 32'(log_b[base]), 32'h53);
    chk("t1_ptr3_next",  32'(log_b[base+1]), 32'h50);

    // ---- 2: four single-byte requesters, twice ----
    do_reset();
    fix_delay = 6;
    for (int rep = 0; rep < 2; rep++) begin
      base = log_n;
      for (int k = 0; k < NR; k++) enqueue(k, 8'(8'h30 + k), 1);
      drain(300, "t2");
      for (int k = 0; k < NR; k++) chk("t2_order", 32'(log_b[base+k]), 32'(8'h30 + k));
    end

    // ---- 3: 5-byte burst then waiting requester ----
    do_reset();
    fix_delay = 10;
    base = log_n;
    for (int j = 0; j < 5; j++) enqueue(0, 8'(8'hA0 + j), j == 4);
    enqueue(1, 8'hB0, 1);
    drain(300, "t3");
    for (int j = 0; j < 5; j++) chk("t3_bytes", 32'(log_b[base+j]), 32'(8'hA0 + j));
    chk("t3_b0", 32'(log_b[base+5]), 32'hB0);
    for (int j = 0; j < 4; j++) chk("t3_gap_done", 32'(log_c[base+j+1] - log_c[base+j]), 10);
    chk("t3_gap_idle", 32'(log_c[base+5] - log_c[base+4]), 11);

    // ---- 4: MAX_BURST cap with a never-last stream ----
    do_reset();
    fix_delay = 5;
    base = log_n;
    for (int j = 0; j < 10; j++) enqueue(0, 8'(8'hC0 + j), 0);
    enqueue(1, 8'hD0, 1);
    drain(400, "t4");
    for (int j = 0; j < MB; j++) chk("t4_first", 32'(log_b[base+j]), 32'(8'hC0 + j));
    chk("t4_other", 32'(log_b[base+MB]), 32'hD0);
    for (int j = MB; j < 10; j++) chk("t4_resume", 32'(log_b[base+j+1]), 32'(8'hC0 + j));

    // ---- 5: watchdog, then done coincident with expiry ----
    do_reset();
    hang_mode = 1;
    base = log_n; a2 = to_n;
    enqueue(0, 8'hE0, 1); enqueue(1, 8'hE1, 1);
    drain(400, "t5");
    chk("t5_timeouts", 32'(to_n - a2), 2);
    chk("t5_regrant",  32'(log_c[base+1] - log_c[base]), 51);
    hang_mode = 0; fix_delay = DT;
    base = log_n; a2 = to_n;
    enqueue(2, 8'hE2, 1);
    drain(400, "t5b");
    chk("t5_coincident_to", 32'(to_n - a2), 0);
    chk("t5_coincident_tx", 32'(log_n - base), 1);

    // ---- 6: reset mid-burst with the transmitter still active ----
    do_reset();
    fix_delay = 10;
    enqueue(1, 8'h61, 1);
    drain(200, "t6a");
    base = log_n;
    for (int j = 0; j < 6; j++) enqueue(2, 8'(8'h70 + j), 0);
    begin
      int n;
      n = 0;
      while (log_n < base + 2 && n < 200) begin @(negedge clk); n++; end
      chk("t6_burst_started", 32'(log_n >= base + 2), 1);
    end
    enqueue(1, 8'h62, 1); enqueue(3, 8'h63, 1);
    @(posedge clk); #2;
    rst = 1; hold = 1;
    #1;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_dv",    32'(tx_dv), 0);
    chk("t6_rst_ack",   32'(ack), 0);
    chk("t6_rst_busy",  32'(busy), 0);
    base = log_n;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (27) @(negedge clk);
    chk("t6_no_dv_while_active", 32'(log_n - base), 0);
    hold = 0;
    drain(600, "t6");
    chk("t6_restart_from_0", 32'(log_b[base]), 32'h62);

    // ---- randomized traffic ----
    do_reset();
    rand_mode = 1;
    for (int t = 0; t < 2500; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        int k, n;
        k = $urandom_range(0, NR - 1);
        if (tail[k] - head[k] < 16) begin
          n = $urandom_range(1, 8);
          for (int j = 0; j < n; j++)
            enqueue(k, 8'($urandom),
                    (j == n - 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0));
        end
      end
    end
    rand_mode = 0;
    drain(5000, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
